// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared inference-datapath types, widths and saturation helper
package nn_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ACC_W  = 32;

    // Widest signed value sat_signed accepts; callers sign-extend into it.
    localparam int SAT_WIDE_W = 64;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } mac_state_t;

    // Clip a sign-extended wide value to acc_w signed bits.
    // Returns {sat_flag, value}; value is the low DEFAULT_ACC_W bits of the clipped result.
    function automatic logic [DEFAULT_ACC_W:0] sat_signed(
        input logic signed [SAT_WIDE_W-1:0] wide,
        input int                           acc_w
    );
        logic signed [SAT_WIDE_W-1:0] hi;
        logic signed [SAT_WIDE_W-1:0] lo;
        logic signed [SAT_WIDE_W-1:0] clipped;
        logic                         flag;
        hi      = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo      = -hi - 64'sd1;
        clipped = wide;
        flag    = 1'b0;
        if (wide > hi) begin
            clipped = hi;
            flag    = 1'b1;
        end else if (wide < lo) begin
            clipped = lo;
            flag    = 1'b1;
        end
        return {flag, clipped[DEFAULT_ACC_W-1:0]};
    endfunction

endpackage

// File: rtl/sat_clip.sv
// rtl/sat_clip.sv - combinational signed clip of a wide accumulator to OUT_W bits
//
// Ports:
//   wide_i  IN_W   signed wide value
//   data_o  OUT_W  clipped signed value
//   sat_o   1      high when wide_i was outside the OUT_W signed range
module sat_clip
    import nn_pkg::*;
#(
    parameter int IN_W  = 36,
    parameter int OUT_W = DEFAULT_ACC_W
) (
    input  logic [IN_W-1:0]  wide_i,
    output logic [OUT_W-1:0] data_o,
    output logic             sat_o
);

    logic [SAT_WIDE_W-1:0]    wide_ext;
    logic [DEFAULT_ACC_W:0]   clip_res;

    assign wide_ext = {{(SAT_WIDE_W-IN_W){wide_i[IN_W-1]}}, wide_i};
    assign clip_res = sat_signed(wide_ext, OUT_W);
    assign sat_o    = clip_res[DEFAULT_ACC_W];
    assign data_o   = clip_res[OUT_W-1:0];

endmodule

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - streaming signed dot-product stage with saturated output
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand-pair handshake (in_ready is a state decode)
//   in_a, in_b           DATA_W signed operands
//   out_valid/out_ready  result handshake
//   out_data             ACC_W signed saturated dot product
//   out_sat              out_data was clipped
module mac_accumulator
    import nn_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ACC_W   = DEFAULT_ACC_W,
    parameter int VEC_LEN = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              out_sat
);

    localparam int PROD_W = 2 * DATA_W;
    // Headroom of clog2(VEC_LEN)+1 bits keeps the running sum exact.
    localparam int AW     = PROD_W + $clog2(VEC_LEN) + 1;
    localparam int CNT_W  = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VEC_LEN - 1);

    mac_state_t        state_q,     state_d;
    logic [AW-1:0]     acc_q,       acc_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  out_data_q,  out_data_d;
    logic              out_sat_q,   out_sat_d;

    logic [PROD_W-1:0] a_ext;
    logic [PROD_W-1:0] b_ext;
    logic [PROD_W-1:0] prod;
    logic [AW-1:0]     prod_ext;
    logic [AW-1:0]     sum;
    logic [ACC_W-1:0]  clip_data;
    logic              clip_sat;
    logic              accept;

    // Sign-extending both operands to the product width makes the low
    // PROD_W bits of an unsigned multiply equal the exact signed product.
    assign a_ext    = {{DATA_W{in_a[DATA_W-1]}}, in_a};
    assign b_ext    = {{DATA_W{in_b[DATA_W-1]}}, in_b};
    assign prod     = a_ext * b_ext;
    assign prod_ext = {{(AW-PROD_W){prod[PROD_W-1]}}, prod};
    assign sum      = acc_q + prod_ext;

    sat_clip #(
        .IN_W  (AW),
        .OUT_W (ACC_W)
    ) u_sat_clip (
        .wide_i (sum),
        .data_o (clip_data),
        .sat_o  (clip_sat)
    );

    assign in_ready = (state_q == ACCUM);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        case (state_q)
            ACCUM: begin
                if (accept) begin
                    if (cnt_q == LAST_CNT) begin
                        out_data_d  = clip_data;
                        out_sat_d   = clip_sat;
                        out_valid_d = 1'b1;
                        acc_d       = '0;
                        cnt_d       = '0;
                        state_d     = HOLD;
                    end else begin
                        acc_d = sum;
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                // HOLD always costs a cycle so no input beat shares a cycle
                // with the output handshake.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                end
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - randomized self-checking bench for mac_accumulator
module tb_mac_accumulator;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int VL = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_a;
    logic [DW-1:0] in_b;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_data;
    logic          out_sat;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    logic signed [DW-1:0] va [VL];
    logic signed [DW-1:0] vb [VL];
    int                   bub [VL];

    mac_accumulator #(
        .DATA_W  (DW),
        .ACC_W   (AW),
        .VEC_LEN (VL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact dot product in 64-bit integers, then clip to 32 bits.
    function automatic longint dot_ref();
        longint s = 0;
        for (int i = 0; i < VL; i++) s += longint'(va[i]) * longint'(vb[i]);
        return s;
    endfunction

    function automatic logic [32:0] sat_ref(input longint s);
        if (s > 64'sd2147483647)       return {1'b1, 32'h7FFF_FFFF};
        else if (s < -64'sd2147483648) return {1'b1, 32'h8000_0000};
        else                           return {1'b0, s[31:0]};
    endfunction

    // Present one vector with bub[i] idle cycles before beat i; checks result
    // and its latency. If out_ready is high also checks the one-cycle pulse.
    task automatic feed(input string tag);
        int          start;
        int          nbub;
        logic [32:0] exp;
        exp   = sat_ref(dot_ref());
        start = cyc;
        nbub  = 0;
        for (int i = 0; i < VL; i++) begin
            for (int k = 0; k < bub[i]; k++) begin
                in_valid = 1'b0;
                @(negedge clk);
                check({tag, " no early valid (bubble)"}, 64'(out_valid), 64'd0);
                nbub++;
            end
            check({tag, " in_ready during vector"}, 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_a     = va[i];
            in_b     = vb[i];
            @(negedge clk);
            if (i < VL - 1) check({tag, " no early valid"}, 64'(out_valid), 64'd0);
        end
        in_valid = 1'b0;
        check({tag, " latency"}, 64'(cyc - start), 64'(VL + nbub));
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " in_ready in hold"}, 64'(in_ready), 64'd0);
        check({tag, " out_data"}, 64'(out_data), 64'(exp[31:0]));
        check({tag, " out_sat"}, 64'(out_sat), 64'(exp[32]));
        if (out_ready) begin
            @(negedge clk);
            check({tag, " valid one cycle"}, 64'(out_valid), 64'd0);
            check({tag, " in_ready after hs"}, 64'(in_ready), 64'd1);
            check({tag, " data kept"}, 64'(out_data), 64'(exp[31:0]));
        end
    endtask

    task automatic set_vec(input int a0, a1, a2, a3, b0, b1, b2, b3);
        va[0] = DW'(a0); va[1] = DW'(a1); va[2] = DW'(a2); va[3] = DW'(a3);
        vb[0] = DW'(b0); vb[1] = DW'(b1); vb[2] = DW'(b2); vb[3] = DW'(b3);
        for (int i = 0; i < VL; i++) bub[i] = 0;
    endtask

    initial begin
        logic [31:0] held;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b1;
        #1;
        check("reset out_valid", 64'(out_valid), 64'd0);
        check("reset out_data", 64'(out_data), 64'd0);
        check("reset out_sat", 64'(out_sat), 64'd0);
        check("reset in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic, negative and saturating vectors.
        set_vec(1, 2, 3, 4, 5, 6, 7, 8);
        feed("basic");
        check("basic value 70", 64'(out_data), 64'd70);
        set_vec(-1, -1, -1, -1, 5, 5, 5, 5);
        feed("negative");
        check("negative value", 64'(out_data), 64'hFFFF_FFEC);
        set_vec(-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768);
        feed("sat_pos");
        set_vec(1, 1, 1, 1, 1, 1, 1, 1);
        feed("after_sat");
        set_vec(-32768, -32768, -32768, -32768, 32767, 32767, 32767, 32767);
        feed("sat_neg");

        // Backpressure: result held, pending beat not consumed until HOLD exits.
        set_vec(2, 2, 2, 2, 3, 3, 3, 3);
        out_ready = 1'b0;
        feed("bp");
        held     = out_data;
        in_valid = 1'b1;
        in_a     = DW'(3);
        in_b     = DW'(3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp valid held", 64'(out_valid), 64'd1);
            check("bp data stable", 64'(out_data), 64'(held));
            check("bp in_ready low", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp hs valid low", 64'(out_valid), 64'd0);
        check("bp in_ready back", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_a = DW'(1);
        in_b = DW'(1);
        for (int k = 0; k < VL - 1; k++) @(negedge clk);
        in_valid = 1'b0;
        check("bp next valid", 64'(out_valid), 64'd1);
        check("bp next data", 64'(out_data), 64'd12);
        @(negedge clk);

        // Three bubbles spread over the gaps between beats.
        set_vec(1, 2, 3, 4, 5, 6, 7, 8);
        for (int k = 0; k < 3; k++) bub[$urandom_range(1, VL - 1)]++;
        feed("bubbles");

        // Randomized vectors with random bubbles, mixing full-range and extreme operands.
        for (int n = 0; n < 12; n++) begin
            for (int i = 0; i < VL; i++) begin
                case ($urandom_range(0, 2))
                    0: va[i] = DW'($urandom);
                    1: va[i] = DW'($urandom_range(0, 15)) - DW'(8);
                    default: va[i] = ($urandom_range(0, 1) != 0) ? 16'sh8000 : 16'sh7FFF;
                endcase
                case ($urandom_range(0, 2))
                    0: vb[i] = DW'($urandom);
                    1: vb[i] = DW'($urandom_range(0, 15)) - DW'(8);
                    default: vb[i] = ($urandom_range(0, 1) != 0) ? 16'sh8000 : 16'sh7FFF;
                endcase
                bub[i] = $urandom_range(0, 2);
            end
            feed("random");
        end

        // Asynchronous reset after two accepted beats discards the partial sum.
        set_vec(1, 2, 3, 4, 5, 6, 7, 8);
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_a     = va[i];
            in_b     = vb[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst out_data", 64'(out_data), 64'd0);
        check("midrst out_sat", 64'(out_sat), 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        feed("post_reset");
        check("post_reset value 70", 64'(out_data), 64'd70);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
